// File: rtl/tl_phase_sched_if.sv
// Sensor, request and lamp bundle for the two-street phase scheduler.
// The master drives the street inputs; the slave (scheduler) drives lamps and debug.
interface tl_phase_sched_if #(
  parameter int CNT_W = 6
);
  logic             Ta;
  logic             Tb;
  logic             Lreq_a;
  logic             Lreq_b;
  logic [1:0]       La;
  logic [1:0]       Lb;
  logic [2:0]       state;
  logic [CNT_W-1:0] phase_cnt;

  modport master (
    output Ta, Tb, Lreq_a, Lreq_b,
    input  La, Lb, state, phase_cnt
  );

  modport slave (
    input  Ta, Tb, Lreq_a, Lreq_b,
    output La, Lb, state, phase_cnt
  );
endinterface

// File: rtl/tl_phase_sched.sv
// Demand-driven traffic phase scheduler: green/yellow/left/left-yellow per street,
// per-phase dwell timer and latched left-turn requests.
module tl_phase_sched #(
  parameter int G_MIN  = 8,
  parameter int G_MAX  = 32,
  parameter int Y_TIME = 3,
  parameter int L_TIME = 6,
  parameter int CNT_W  = 6
) (
  input logic              clk,
  input logic              reset_n,
  tl_phase_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_AG  = 3'b000,
    S_AY  = 3'b001,
    S_AL  = 3'b010,
    S_ALY = 3'b011,
    S_BG  = 3'b100,
    S_BY  = 3'b101,
    S_BL  = 3'b110,
    S_BLY = 3'b111
  } state_e;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_LEFT   = 2'b10;
  localparam logic [1:0] LAMP_RED    = 2'b11;

  localparam logic [CNT_W-1:0] G_MIN_M1  = CNT_W'(G_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX_M1  = CNT_W'(G_MAX - 1);
  localparam logic [CNT_W-1:0] Y_TIME_M1 = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] L_TIME_M1 = CNT_W'(L_TIME - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_a_q, pend_b_q;
  logic             demand_a, demand_b;
  logic             min_done, max_done, y_done, l_done;
  logic             serve_a, serve_b;
  logic             a_left_active, b_left_active;

  // A pending left on the cross street ends the current green just like a car would.
  assign demand_a = bus.Ta | pend_a_q;
  assign demand_b = bus.Tb | pend_b_q;

  assign min_done = (cnt_q >= G_MIN_M1);
  assign max_done = (cnt_q == G_MAX_M1);
  assign y_done   = (cnt_q == Y_TIME_M1);
  assign l_done   = (cnt_q == L_TIME_M1);

  assign a_left_active = (state_q == S_AL) || (state_q == S_ALY);
  assign b_left_active = (state_q == S_BL) || (state_q == S_BLY);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    serve_a = 1'b0;
    serve_b = 1'b0;
    unique case (state_q)
      S_AG:  if (demand_b && (max_done || (min_done && !bus.Ta))) state_d = S_AY;
      S_AY:  if (y_done) begin
               if (pend_a_q) begin
                 state_d = S_AL;
                 serve_a = 1'b1;
               end else begin
                 state_d = S_BG;
               end
             end
      S_AL:  if (l_done) state_d = S_ALY;
      S_ALY: if (y_done) state_d = S_BG;
      S_BG:  if (demand_a && (max_done || (min_done && !bus.Tb))) state_d = S_BY;
      S_BY:  if (y_done) begin
               if (pend_b_q) begin
                 state_d = S_BL;
                 serve_b = 1'b1;
               end else begin
                 state_d = S_AG;
               end
             end
      S_BL:  if (l_done) state_d = S_BLY;
      S_BLY: if (y_done) state_d = S_AG;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_AG;
      cnt_q    <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (!max_done) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // A request landing on the serving edge is absorbed by that service.
      pend_a_q <= (pend_a_q | (bus.Lreq_a & ~a_left_active)) & ~serve_a;
      pend_b_q <= (pend_b_q | (bus.Lreq_b & ~b_left_active)) & ~serve_b;
    end
  end

  // Lamps decode only from the state register, so they never glitch on input changes.
  always_comb begin
    bus.La = LAMP_RED;
    bus.Lb = LAMP_RED;
    unique case (state_q)
      S_AG:         bus.La = LAMP_GREEN;
      S_AY, S_ALY:  bus.La = LAMP_YELLOW;
      S_AL:         bus.La = LAMP_LEFT;
      S_BG:         bus.Lb = LAMP_GREEN;
      S_BY, S_BLY:  bus.Lb = LAMP_YELLOW;
      S_BL:         bus.Lb = LAMP_LEFT;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.phase_cnt = cnt_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Self-checking bench for tl_phase_sched: phase-level reference model compared every cycle,
// directed scenarios with hand-computed timing, then randomized traffic with sporadic resets.
module tb_tl_phase_sched;

  localparam int G_MIN  = 8;
  localparam int G_MAX  = 32;
  localparam int Y_TIME = 3;
  localparam int L_TIME = 6;
  localparam int CNT_W  = 6;

  typedef enum int {GRN = 0, YEL = 1, LFT = 2, LYEL = 3} kind_e;

  typedef struct {
    int       street;   // 0 = A, 1 = B
    kind_e    kind;
    int       elapsed;
    bit [1:0] pend;     // [0] = A, [1] = B
  } model_t;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  model_t m;

  tl_phase_sched_if #(.CNT_W(CNT_W)) bus ();

  tl_phase_sched #(
    .G_MIN(G_MIN), .G_MAX(G_MAX), .Y_TIME(Y_TIME), .L_TIME(L_TIME), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.street  = 0;
    r.kind    = GRN;
    r.elapsed = 0;
    r.pend    = 2'b00;
    return r;
  endfunction

  // One clock of the intersection rules: decide the phase change, then update bookkeeping.
  function automatic model_t step(model_t cur, bit ta, bit tb, bit [1:0] lr);
    model_t   nxt = cur;
    bit [1:0] car = {tb, ta};
    int       own = cur.street;
    int       oth = 1 - cur.street;
    bit       serve = 1'b0;
    case (cur.kind)
      GRN: if ((car[oth] | cur.pend[oth]) &&
               (cur.elapsed >= G_MAX - 1 || (cur.elapsed >= G_MIN - 1 && !car[own])))
             nxt.kind = YEL;
      YEL: if (cur.elapsed == Y_TIME - 1) begin
             if (cur.pend[own]) begin
               nxt.kind = LFT;
               serve = 1'b1;
             end else begin
               nxt.street = oth;
               nxt.kind = GRN;
             end
           end
      LFT: if (cur.elapsed == L_TIME - 1) nxt.kind = LYEL;
      LYEL: if (cur.elapsed == Y_TIME - 1) begin
              nxt.street = oth;
              nxt.kind = GRN;
            end
      default: ;
    endcase
    for (int i = 0; i < 2; i++) begin
      bit in_left = (cur.street == i) && (cur.kind == LFT || cur.kind == LYEL);
      nxt.pend[i] = (cur.pend[i] | (lr[i] & !in_left)) & !(serve && own == i);
    end
    if (nxt.street != cur.street || nxt.kind != cur.kind) nxt.elapsed = 0;
    else if (cur.elapsed < G_MAX - 1) nxt.elapsed = cur.elapsed + 1;
    return nxt;
  endfunction

  function automatic int own_lamp(kind_e k);
    case (k)
      GRN:     return 0;
      LFT:     return 2;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= step(m, bus.Ta, bus.Tb, {bus.Lreq_b, bus.Lreq_a});
  end

  always @(negedge clk) begin
    check("model_state", bus.state, 32'(m.street * 4 + int'(m.kind)));
    check("model_cnt", bus.phase_cnt, 32'(m.elapsed));
    check("model_La", bus.La, 32'((m.street == 0) ? own_lamp(m.kind) : 3));
    check("model_Lb", bus.Lb, 32'((m.street == 1) ? own_lamp(m.kind) : 3));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit ta, input bit tb, input bit la, input bit lb);
    bus.Ta = ta;
    bus.Tb = tb;
    bus.Lreq_a = la;
    bus.Lreq_b = lb;
  endtask

  // Holds reset for two edges; the first edge after release is cycle 0's decision edge.
  task automatic do_reset(input bit ta, input bit tb);
    @(posedge clk);
    #1 reset_n = 1'b0;
    set_in(ta, tb, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic expect_lit(input string name, input int st, input int la, input int lb);
    check({name, "_state"}, bus.state, 32'(st));
    check({name, "_La"}, bus.La, 32'(la));
    check({name, "_Lb"}, bus.Lb, 32'(lb));
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    expect_lit("reset_hold", 0, 0, 3);
    check("reset_hold_cnt", bus.phase_cnt, 0);

    // Idle intersection: A green forever, timer saturates.
    do_reset(1'b0, 1'b0);
    tick(50);
    expect_lit("idle", 0, 0, 3);
    check("idle_cnt_sat", bus.phase_cnt, 31);

    // B traffic only: A green ends at G_MIN.
    do_reset(1'b0, 1'b1);
    tick(7);  expect_lit("gmin_ag", 0, 0, 3);
    check("gmin_ag_cnt", bus.phase_cnt, 7);
    tick(1);  expect_lit("gmin_ay", 1, 1, 3);
    tick(3);  expect_lit("gmin_bg", 4, 3, 0);

    // Both streets busy: greens run to G_MAX.
    do_reset(1'b1, 1'b1);
    tick(31); expect_lit("gmax_ag", 0, 0, 3);
    tick(1);  expect_lit("gmax_ay", 1, 1, 3);
    tick(3);  expect_lit("gmax_bg", 4, 3, 0);
    tick(31); expect_lit("gmax_bg_hold", 4, 3, 0);
    tick(1);  expect_lit("gmax_by", 5, 3, 1);
    tick(3);  expect_lit("gmax_ag2", 0, 0, 3);

    // Left request on A is served once; a request during the arrow is dropped.
    do_reset(1'b0, 1'b1);
    tick(2);  set_in(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);  set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick(5);  expect_lit("la_ay", 1, 1, 3);
    tick(3);  expect_lit("la_al", 2, 2, 3);
    tick(1);  set_in(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);  set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick(4);  expect_lit("la_aly", 3, 1, 3);
    tick(3);  expect_lit("la_bg", 4, 3, 0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick(8);  expect_lit("la_by", 5, 3, 1);
    tick(3);  expect_lit("la_ag", 0, 0, 3);
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick(8);  expect_lit("la_ay2", 1, 1, 3);
    tick(3);  expect_lit("la_no_reserve", 4, 3, 0);

    // Simultaneous left requests: A left first, B green holds on pend_b alone.
    do_reset(1'b0, 1'b1);
    tick(2);  set_in(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);  set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick(8);  expect_lit("both_al", 2, 2, 3);
    tick(9);  expect_lit("both_bg", 4, 3, 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    tick(30); expect_lit("both_bg_hold", 4, 3, 0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);  expect_lit("both_by", 5, 3, 1);
    tick(3);  expect_lit("both_bl", 6, 3, 2);
    tick(6);  expect_lit("both_bly", 7, 3, 1);
    tick(3);  expect_lit("both_ag", 0, 0, 3);

    // Asynchronous reset in the middle of the A left arrow.
    do_reset(1'b0, 1'b1);
    tick(2);  set_in(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);  set_in(1'b0, 1'b1, 1'b0, 1'b0);
    tick(10); expect_lit("arst_pre", 2, 2, 3);
    #2 reset_n = 1'b0;
    #1 expect_lit("arst_now", 0, 0, 3);
    check("arst_cnt", bus.phase_cnt, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(8);  expect_lit("arst_ay", 1, 1, 3);
    tick(3);  expect_lit("arst_no_left", 4, 3, 0);

    // Randomized traffic with sticky sensors, sparse requests and rare async resets.
    do_reset(1'b0, 1'b0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 7) == 0) bus.Ta = ~bus.Ta;
      if ($urandom_range(0, 7) == 0) bus.Tb = ~bus.Tb;
      bus.Lreq_a = ($urandom_range(0, 15) == 0);
      bus.Lreq_b = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
      end
    end
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_phase_sched.md
Name: tl_phase_sched

Overview:
Timed phase scheduler for a two-street intersection (street A, street B) with protected left-turn phases. It sequences the green, yellow, left and red lamp codes on the La/Lb outputs. Inputs are vehicle-presence sensors (Ta, Tb) and latched left-turn requests. It replaces a free-running state counter with a demand-driven FSM, per-phase dwell timers and pending-request bookkeeping.

Parameters:
G_MIN, 8, minimum green dwell in cycles (>=1)
G_MAX, 32, maximum green dwell once the cross street has demand (G_MIN <= G_MAX <= 2^CNT_W)
Y_TIME, 3, yellow dwell in cycles (>=1)
L_TIME, 6, left-arrow dwell in cycles (>=1)
CNT_W, 6, phase timer width

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
Ta  input  1  vehicle present on street A (level)
Tb  input  1  vehicle present on street B (level)
Lreq_a  input  1  left-turn request, street A (pulse or level)
Lreq_b  input  1  left-turn request, street B (pulse or level)
La  output  2  lamp code, street A
Lb  output  2  lamp code, street B
state  output  3  current FSM state (debug)
phase_cnt  output  CNT_W  cycles elapsed in current state (debug)

Behaviour:
- Lamp codes: 2'b00 green, 2'b01 yellow, 2'b10 left arrow, 2'b11 red.
- One clock domain; reset_n is asynchronous and active-low.
- States: S_AG=000, S_AY=001, S_AL=010, S_ALY=011, S_BG=100, S_BY=101, S_BL=110, S_BLY=111.
- La/Lb are decoded purely from the state register, so they are glitch-free and change one edge after a transition decision.
  - S_AG: La=00, Lb=11.
  - S_AY and S_ALY: La=01, Lb=11.
  - S_AL: La=10, Lb=11.
  - B states mirror the A states with La and Lb swapped.
- Reset values: state=S_AG, phase_cnt=0, pend_a=0, pend_b=0, La=00, Lb=11. Reset is honoured mid-phase, and all pending requests are discarded.
- phase_cnt:
  - Clears to 0 on the edge that enters a new state.
  - Otherwise increments by 1 per cycle.
  - Saturates at G_MAX-1 and never wraps.
- Demand signals: demand_b = Tb | pend_b; demand_a = Ta | pend_a.
- Transitions, checked each edge; only one transition per edge:
  - S_AG -> S_AY when demand_b && (phase_cnt==G_MAX-1 || (phase_cnt>=G_MIN-1 && !Ta)).
    - With no B demand, stay in S_AG indefinitely; the counter saturates.
  - S_AY -> S_AL when phase_cnt==Y_TIME-1 && pend_a; S_AY -> S_BG when phase_cnt==Y_TIME-1 && !pend_a.
  - S_AL -> S_ALY when phase_cnt==L_TIME-1.
  - S_ALY -> S_BG when phase_cnt==Y_TIME-1.
  - B side is symmetric, using demand_a, Tb and pend_b, and returns to S_AG.
- Pending left requests:
  - pend_a <= (pend_a | Lreq_a) & ~(S_AY->S_AL transition this edge).
  - Lreq_a is ignored while state is S_AL or S_ALY.
  - pend_b follows the same rules.
  - A request arriving on the same edge as the serving transition is absorbed by that service.
  - Requests for the other street latch in any state and are never lost.
- A pending left counts as cross-street demand, so an empty cross street with pend_b=1 still forces the A green to end.
- Ta/Tb are sampled synchronously; the bench must drive them synchronous to clk.

Test Plan:
1. Reset, Ta=Tb=0, no requests, 50 cycles -> La=00, Lb=11 throughout; phase_cnt saturates at 31; state stays 000.
2. Release reset, Tb=1, Ta=0 from cycle 0 -> S_AG cycles 0-7, S_AY cycles 8-10 (La=01), S_BG from cycle 11 (La=11, Lb=00).
3. Ta=1, Tb=1 held -> S_AG exactly 32 cycles, then S_AY 3 cycles, then S_BG. In S_BG with Ta=1, Tb=1: exit after 32 cycles.
4. Tb=1, Ta=0, one-cycle Lreq_a pulse at cycle 2 -> S_AG 8, S_AY 3, S_AL 6 (La=10, Lb=11), S_ALY 3, S_BG at cycle 20. pend_a=0 from S_AL entry. A second Lreq_a during S_AL is not served again.
5. Lreq_a and Lreq_b pulsed in the same cycle during S_AG, Tb=1, Ta=0 -> A left phase served first. Then S_BG, and with Ta=0 the B green holds (pend_b does not count toward demand_a). When Ta=1: S_BG ends at G_MIN, then S_BY, S_BL, S_BLY, S_AG.
6. reset_n dropped asynchronously mid-S_AL -> La=00, Lb=11 immediately without a clock edge; phase_cnt=0, pend_a=pend_b=0. After release, normal operation from S_AG.
